pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_pkg.sv | 17 +
 rtl/pong_game_ctrl_frame_timer.sv | 18 +
 rtl/pong_game_ctrl.sv | 115 +++++++++++
 tb/tb_pong_game_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state codes, tone codes and default frame constants for the pong controller.
package pong_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;
  localparam logic [1:0] TONE_PADDLE = 2'd0;
  localparam logic [1:0] TONE_WALL   = 2'd1;
  localparam logic [1:0] TONE_SCORE  = 2'd2;
  localparam int DEF_SERVE_FRAMES = 64;
  localparam int DEF_POINT_FRAMES = 32;
  localparam int DEF_WIN_SCORE    = 9;
  localparam int DEF_SOUND_FRAMES = 6;
endpackage

// File: rtl/pong_game_ctrl_frame_timer.sv
// frame_timer: loadable 8-bit frame countdown; expire fires on the tick that finds the count at or below 1.
module frame_timer (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  output logic       expire
);
  logic [7:0] cnt;
  assign expire = tick && cnt <= 8'd1;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && !expire) cnt <= cnt - 8'd1;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong game sequencer with BCD scoring, serve/point pacing and prioritised tone requests.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SOUND_FRAMES = DEF_SOUND_FRAMES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       start_game,
  input  logic       score0_evt,
  input  logic       score1_evt,
  input  logic       paddle_hit,
  input  logic       wall_hit,
  output logic [2:0] state,
  output logic       ball_run,
  output logic       ball_center,
  output logic       serve_dir,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [1:0] winner,
  output logic       tone_on,
  output logic [1:0] tone_sel
);
  state_t     cur, nxt;
  logic [3:0] s0_n, s1_n;
  logic [1:0] win_n, t_code, tsel_n;
  logic [7:0] g_val;
  logic       dir_n, bc_n, ton_n, g_load, g_exp, s_exp, scored, t_req, t_acc;
  assign state = cur;
  frame_timer u_game (
    .clk(clk), .resetn(resetn), .clr(!start_game), .load(g_load), .load_val(g_val),
    .tick(frame_tick && (cur == SERVE || cur == POINT)), .expire(g_exp)
  );
  frame_timer u_sound (
    .clk(clk), .resetn(resetn), .clr(!start_game), .load(t_acc), .load_val(8'(SOUND_FRAMES)),
    .tick(frame_tick && tone_on), .expire(s_exp)
  );
  always_comb begin
    nxt    = cur;
    s0_n   = score0;
    s1_n   = score1;
    win_n  = winner;
    dir_n  = serve_dir;
    bc_n   = 1'b0;
    g_load = 1'b0;
    g_val  = 8'(SERVE_FRAMES);
    scored = 1'b0;
    if (!start_game) begin
      nxt   = IDLE;
      s0_n  = '0;
      s1_n  = '0;
      win_n = '0;
      dir_n = 1'b0;
    end else case (cur)
      IDLE: if (frame_tick) begin
        nxt    = SERVE;
        bc_n   = 1'b1;
        g_load = 1'b1;
      end
      SERVE: if (g_exp) nxt = PLAY;
      PLAY: if (score0_evt || score1_evt) begin
        scored = 1'b1;
        dir_n  = !score0_evt;
        if (score0_evt) s0_n = score0 + 4'd1;
        else s1_n = score1 + 4'd1;
        if ((score0_evt ? s0_n : s1_n) == 4'(WIN_SCORE)) begin
          nxt   = GAME_OVER;
          win_n = score0_evt ? 2'd1 : 2'd2;
        end else begin
          nxt    = POINT;
          g_load = 1'b1;
          g_val  = 8'(POINT_FRAMES);
        end
      end
      POINT: if (g_exp) begin
        nxt    = SERVE;
        bc_n   = 1'b1;
        g_load = 1'b1;
      end
      default: ;
    endcase
    // a fresh accept outranks expiry of the running tone in the same cycle
    t_req  = scored || (start_game && cur == PLAY && (wall_hit || paddle_hit));
    t_code = scored ? TONE_SCORE : wall_hit ? TONE_WALL : TONE_PADDLE;
    t_acc  = t_req && (!tone_on || t_code >= tone_sel);
    ton_n  = !start_game ? 1'b0 : t_acc ? 1'b1 : (tone_on && s_exp) ? 1'b0 : tone_on;
    tsel_n = t_acc ? t_code : tone_sel;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cur         <= IDLE;
      ball_run    <= 1'b0;
      ball_center <= 1'b0;
      serve_dir   <= 1'b0;
      score0      <= '0;
      score1      <= '0;
      winner      <= '0;
      tone_on     <= 1'b0;
      tone_sel    <= '0;
    end else begin
      cur         <= nxt;
      ball_run    <= nxt == PLAY;
      ball_center <= bc_n;
      serve_dir   <= dir_n;
      score0      <= s0_n;
      score1      <= s1_n;
      winner      <= win_n;
      tone_on     <= ton_n;
      tone_sel    <= tsel_n;
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scoreboard bench for pong_game_ctrl; two instances differ only in WIN_SCORE.
module tb_pong_game_ctrl;
  logic clk = 0, resetn = 0, frame_tick = 0, start_game = 0;
  logic score0_evt = 0, score1_evt = 0, paddle_hit = 0, wall_hit = 0;
  logic [2:0] a_state, b_state;
  logic a_run, b_run, a_bc, b_bc, a_dir, b_dir, a_ton, b_ton;
  logic [3:0] a_s0, b_s0, a_s1, b_s1;
  logic [1:0] a_win, b_win, a_tsel, b_tsel;
  localparam int S_ST = 0, S_RUN = 1, S_BC = 2, S_DIR = 3, S_S0 = 4, S_S1 = 5, S_WIN = 6, S_TON = 7, S_TSEL = 8, B = 16;
  always #5 clk = ~clk;
  pong_game_ctrl #(.SERVE_FRAMES(3), .POINT_FRAMES(2), .WIN_SCORE(2), .SOUND_FRAMES(3)) dut_a (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .start_game(start_game),
    .score0_evt(score0_evt), .score1_evt(score1_evt), .paddle_hit(paddle_hit), .wall_hit(wall_hit),
    .state(a_state), .ball_run(a_run), .ball_center(a_bc), .serve_dir(a_dir),
    .score0(a_s0), .score1(a_s1), .winner(a_win), .tone_on(a_ton), .tone_sel(a_tsel)
  );
  pong_game_ctrl #(.SERVE_FRAMES(3), .POINT_FRAMES(2), .WIN_SCORE(9), .SOUND_FRAMES(3)) dut_b (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .start_game(start_game),
    .score0_evt(score0_evt), .score1_evt(score1_evt), .paddle_hit(paddle_hit), .wall_hit(wall_hit),
    .state(b_state), .ball_run(b_run), .ball_center(b_bc), .serve_dir(b_dir),
    .score0(b_s0), .score1(b_s1), .winner(b_win), .tone_on(b_ton), .tone_sel(b_tsel)
  );
  typedef struct {
    int    sel;
    int    exp;
    string name;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  int n_chk = 0, n_fail = 0;
  function automatic int actual(input int sel);
    case (sel)
      S_ST:       return int'(a_state);
      S_RUN:      return int'(a_run);
      S_BC:       return int'(a_bc);
      S_DIR:      return int'(a_dir);
      S_S0:       return int'(a_s0);
      S_S1:       return int'(a_s1);
      S_WIN:      return int'(a_win);
      S_TON:      return int'(a_ton);
      S_TSEL:     return int'(a_tsel);
      B + S_ST:   return int'(b_state);
      B + S_RUN:  return int'(b_run);
      B + S_BC:   return int'(b_bc);
      B + S_DIR:  return int'(b_dir);
      B + S_S0:   return int'(b_s0);
      B + S_S1:   return int'(b_s1);
      B + S_WIN:  return int'(b_win);
      B + S_TON:  return int'(b_ton);
      B + S_TSEL: return int'(b_tsel);
      default:    return -1;
    endcase
  endfunction
  task automatic expect_v(input string name, input int sel, input int exp);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask
  task automatic step(input logic ft, input logic s0, input logic s1, input logic ph, input logic wh);
    frame_tick = ft;
    score0_evt = s0;
    score1_evt = s1;
    paddle_hit = ph;
    wall_hit   = wh;
    @(posedge clk);
    #1;
    frame_tick = 0;
    score0_evt = 0;
    score1_evt = 0;
    paddle_hit = 0;
    wall_hit   = 0;
  endtask
  always @(negedge clk)
    while (q.size() > 0) begin
      e_m = q.pop_front();
      n_chk++;
      if (actual(e_m.sel) !== e_m.exp) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", e_m.name, actual(e_m.sel), e_m.exp);
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_v("rst_state", S_ST, 0);
    expect_v("rst_run", S_RUN, 0);
    expect_v("rst_score0", S_S0, 0);
    expect_v("rst_tone", S_TON, 0);
    resetn = 1;
    start_game = 1;
    step(1, 0, 0, 0, 0);
    expect_v("serve_state", S_ST, 1);
    expect_v("serve_center", S_BC, 1);
    expect_v("serve_run", S_RUN, 0);
    step(1, 0, 0, 0, 0);
    expect_v("center_pulse_end", S_BC, 0);
    step(1, 0, 0, 0, 0);
    expect_v("serve_hold_2tick", S_ST, 1);
    step(1, 0, 0, 0, 0);
    expect_v("play_after_3", S_ST, 2);
    expect_v("play_run", S_RUN, 1);
    step(0, 0, 0, 1, 0);
    expect_v("paddle_tone_on", S_TON, 1);
    expect_v("paddle_tone_sel", S_TSEL, 0);
    step(1, 0, 0, 0, 1);
    expect_v("wall_tone_sel", S_TSEL, 1);
    expect_v("wall_tone_on", S_TON, 1);
    step(0, 0, 0, 1, 0);
    expect_v("paddle_rejected", S_TSEL, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_v("tone_hold_2tick", S_TON, 1);
    step(1, 0, 0, 0, 0);
    expect_v("tone_off_3tick", S_TON, 0);
    expect_v("still_play", S_ST, 2);
    step(0, 0, 1, 0, 0);
    expect_v("p1_point_state", S_ST, 3);
    expect_v("p1_score1", S_S1, 1);
    expect_v("p1_dir", S_DIR, 1);
    expect_v("p1_run_off", S_RUN, 0);
    expect_v("p1_tone_sel", S_TSEL, 2);
    expect_v("p1_tone_on", S_TON, 1);
    step(1, 0, 0, 0, 0);
    expect_v("point_hold", S_ST, 3);
    step(1, 0, 0, 0, 0);
    expect_v("point_to_serve", S_ST, 1);
    expect_v("point_center", S_BC, 1);
    repeat (3) step(1, 0, 0, 0, 0);
    expect_v("replay", S_ST, 2);
    step(0, 1, 1, 0, 0);
    expect_v("both_score0", S_S0, 1);
    expect_v("both_score1", S_S1, 1);
    expect_v("both_dir", S_DIR, 0);
    expect_v("both_point", S_ST, 3);
    repeat (5) step(1, 0, 0, 0, 0);
    expect_v("replay2", S_ST, 2);
    step(0, 1, 0, 0, 0);
    expect_v("win_state", S_ST, 4);
    expect_v("win_winner", S_WIN, 1);
    expect_v("win_score0", S_S0, 2);
    expect_v("win_run_off", S_RUN, 0);
    expect_v("b_no_win_state", B + S_ST, 3);
    expect_v("b_no_win_winner", B + S_WIN, 0);
    step(0, 0, 1, 0, 1);
    expect_v("over_ignore_s1", S_S1, 1);
    step(1, 1, 0, 0, 0);
    expect_v("over_hold_state", S_ST, 4);
    expect_v("over_hold_s0", S_S0, 2);
    expect_v("over_hold_win", S_WIN, 1);
    start_game = 0;
    step(0, 0, 0, 0, 0);
    expect_v("stop_state", S_ST, 0);
    expect_v("stop_s0", S_S0, 0);
    expect_v("stop_s1", S_S1, 0);
    expect_v("stop_win", S_WIN, 0);
    expect_v("stop_tone", S_TON, 0);
    start_game = 1;
    step(1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    expect_v("b_play", B + S_ST, 2);
    for (int k = 0; k < 6; k++) begin
      if (k < 5) step(0, 1, 0, 0, 0);
      else step(0, 0, 1, 0, 0);
      if (k < 5) repeat (5) step(1, 0, 0, 0, 0);
    end
    expect_v("b_point", B + S_ST, 3);
    expect_v("b_score0_5", B + S_S0, 5);
    expect_v("b_score1_1", B + S_S1, 1);
    expect_v("b_dir_1", B + S_DIR, 1);
    expect_v("b_tone_on", B + S_TON, 1);
    expect_v("b_tone_sel", B + S_TSEL, 2);
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
    resetn = 0;
    #1;
    n_chk++;
    if (b_state !== 3'd0 || b_s0 !== 4'd0 || b_s1 !== 4'd0) begin
      n_fail++;
      $display("FAIL arst_direct_state_scores: state %0d s0 %0d s1 %0d", b_state, b_s0, b_s1);
    end
    n_chk++;
    if (b_ton !== 1'b0 || b_tsel !== 2'd0) begin
      n_fail++;
      $display("FAIL arst_direct_tone: on %0d sel %0d", b_ton, b_tsel);
    end
    n_chk++;
    if (b_run !== 1'b0 || b_dir !== 1'b0 || b_bc !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_direct_ball: run %0d dir %0d bc %0d", b_run, b_dir, b_bc);
    end
    n_chk++;
    if (b_win !== 2'd0) begin
      n_fail++;
      $display("FAIL arst_direct_winner: %0d", b_win);
    end
    n_chk++;
    if (a_state !== 3'd0) begin
      n_fail++;
      $display("FAIL arst_direct_a_state: %0d", a_state);
    end
    expect_v("arst_state", B + S_ST, 0);
    expect_v("arst_s0", B + S_S0, 0);
    expect_v("arst_s1", B + S_S1, 0);
    expect_v("arst_dir", B + S_DIR, 0);
    expect_v("arst_tone_on", B + S_TON, 0);
    expect_v("arst_tone_sel", B + S_TSEL, 0);
    expect_v("arst_run", B + S_RUN, 0);
    expect_v("arst_a_state", S_ST, 0);
    @(posedge clk);
    #1;
    resetn = 1;
    step(0, 0, 0, 0, 0);
    n_chk++;
    if (b_state !== 3'd0 || b_bc !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_direct: state %0d bc %0d", b_state, b_bc);
    end
    expect_v("post_rst_idle", B + S_ST, 0);
    expect_v("post_rst_center", B + S_BC, 0);
    expect_v("post_rst_tone", B + S_TON, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
